// File: rtl/joy_pkg.sv
// Shared constants for the DB9 multiplexed joystick reader: scan geometry,
// the steps whose samples are kept, raw-line and output bit positions, and
// the sequencer state type.
package joy_pkg;

  localparam int NUM_STEPS = 8;

  // Steps whose end-of-step sample is stored in the per-port shadows.
  localparam logic [2:0] STEP_DPAD   = 3'd0;
  localparam logic [2:0] STEP_ABS    = 3'd1;
  localparam logic [2:0] STEP_DETECT = 3'd5;
  localparam logic [2:0] STEP_XYZ    = 3'd6;

  // Raw DB9 line positions (active-low).
  localparam int IN_UP    = 0;
  localparam int IN_DOWN  = 1;
  localparam int IN_LEFT  = 2;
  localparam int IN_RIGHT = 3;
  localparam int IN_B     = 4;
  localparam int IN_C     = 5;
  // Same lines carry other buttons in the select-low and extended steps.
  localparam int IN_A     = 4;
  localparam int IN_START = 5;
  localparam int IN_Z     = 0;
  localparam int IN_Y     = 1;
  localparam int IN_X     = 2;
  localparam int IN_MODE  = 3;

  // Decoded joyN bit positions.
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE1 = 4;
  localparam int JOY_FIRE2 = 5;
  localparam int JOY_A     = 6;
  localparam int JOY_START = 7;

  // Decoded joyN_ext bit positions.
  localparam int EXT_Z    = 0;
  localparam int EXT_Y    = 1;
  localparam int EXT_X    = 2;
  localparam int EXT_MODE = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_UPDATE
  } state_e;

endpackage

// File: rtl/joy_mux_reader_if.sv
// Link between the scan sequencer and one port decoder: synchronised pad
// lines and sample/update strobes one way, decoded button state the other.
interface joy_mux_reader_if;
  logic [5:0] pad;     // synchronised raw DB9 lines, active-low
  logic       sample;  // last cycle of the current step
  logic [2:0] step;    // current scan step
  logic       update;  // single UPDATE cycle
  logic [7:0] joy;
  logic [3:0] ext;
  logic       six;

  modport master (output pad, sample, step, update, input joy, ext, six);
  modport slave  (input pad, sample, step, update, output joy, ext, six);
endinterface

// File: rtl/joy_port_decode.sv
// Per-port sampler and decoder: keeps the samples of the interesting scan
// steps in shadow registers and publishes the decoded pad state atomically
// on the UPDATE cycle.
module joy_port_decode
  import joy_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  joy_mux_reader_if.slave  bus
);

  logic [5:0] dpad_q;    // step 0: C, B, right, left, down, up
  logic [5:2] abs_q;     // step 1: start, A, right, left
  logic [3:0] detect_q;  // step 5: right, left, down, up
  logic [3:0] xyz_q;     // step 6: mode, X, Y, Z

  logic       present;
  logic       six_btn;
  logic [7:0] joy_d, joy_q;
  logic [3:0] ext_d, ext_q;
  logic       six_q;

  // Capture the end-of-step sample of each step that carries information.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      dpad_q   <= '1;
      abs_q    <= '1;
      detect_q <= '1;
      xyz_q    <= '1;
    end else if (bus.sample) begin
      case (bus.step)
        STEP_DPAD:   dpad_q   <= bus.pad;
        STEP_ABS:    abs_q    <= bus.pad[5:2];
        STEP_DETECT: detect_q <= bus.pad[3:0];
        STEP_XYZ:    xyz_q    <= bus.pad[3:0];
        default: ;
      endcase
    end
  end

  // Decode pad type and buttons from the shadows.
  always_comb begin
    present = ~abs_q[IN_LEFT] & ~abs_q[IN_RIGHT];
    six_btn = present & ~(|detect_q);

    joy_d            = 8'hFF;
    joy_d[JOY_RIGHT] = dpad_q[IN_RIGHT];
    joy_d[JOY_LEFT]  = dpad_q[IN_LEFT];
    joy_d[JOY_DOWN]  = dpad_q[IN_DOWN];
    joy_d[JOY_UP]    = dpad_q[IN_UP];
    joy_d[JOY_FIRE1] = dpad_q[IN_B];
    joy_d[JOY_FIRE2] = dpad_q[IN_C];
    if (present) begin
      joy_d[JOY_A]     = abs_q[IN_A];
      joy_d[JOY_START] = abs_q[IN_START];
    end

    ext_d = 4'hF;
    if (six_btn) begin
      ext_d[EXT_Z]    = xyz_q[IN_Z];
      ext_d[EXT_Y]    = xyz_q[IN_Y];
      ext_d[EXT_X]    = xyz_q[IN_X];
      ext_d[EXT_MODE] = xyz_q[IN_MODE];
    end
  end

  // Publish all outputs together, only on the UPDATE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      joy_q <= 8'hFF;
      ext_q <= 4'hF;
      six_q <= 1'b0;
    end else if (bus.update) begin
      joy_q <= joy_d;
      ext_q <= ext_d;
      six_q <= six_btn;
    end
  end

  assign bus.joy = joy_q;
  assign bus.ext = ext_q;
  assign bus.six = six_q;

endmodule

// File: rtl/joy_mux_reader.sv
// Two-port DB9 Sega/Atari joystick reader: synchronises the pad lines,
// sequences the shared select line through an 8-step scan after each idle
// gap, and hands sampling/decoding to one joy_port_decode per port.
module joy_mux_reader
  import joy_pkg::*;
#(
  parameter int PHASE_CYCLES = 500,
  parameter int IDLE_CYCLES  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] JOYSTICK1,
  input  logic [5:0] JOYSTICK2,
  output logic       JOY_SELECT,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic [3:0] joy1_ext,
  output logic [3:0] joy2_ext,
  output logic       joy1_6btn,
  output logic       joy2_6btn
);

  localparam int PHASE_W = $clog2(PHASE_CYCLES + 1);
  localparam int IDLE_W  = $clog2(IDLE_CYCLES + 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PHASE_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [2:0]         STEP_LAST  = 3'(NUM_STEPS - 1);

  logic [5:0] j1_meta_q, j1_sync_q, j2_meta_q, j2_sync_q;

  state_e             state_q, state_d;
  logic [2:0]         step_q, step_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               sel_q, sel_d;
  logic               scan_sample, scan_update;

  // Two-flop synchronisers; idle level of the pad lines is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      j1_meta_q <= '1;
      j1_sync_q <= '1;
      j2_meta_q <= '1;
      j2_sync_q <= '1;
    end else begin
      j1_meta_q <= JOYSTICK1;
      j1_sync_q <= j1_meta_q;
      j2_meta_q <= JOYSTICK2;
      j2_sync_q <= j2_meta_q;
    end
  end

  // Sequencer state, counters and registered select line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      phase_q <= '0;
      idle_q  <= '0;
      sel_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      idle_q  <= idle_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic: idle gap, eight timed steps, one update cycle.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    phase_d     = phase_q;
    idle_d      = idle_q;
    scan_sample = 1'b0;
    scan_update = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (idle_q == IDLE_LAST) begin
          idle_d  = '0;
          phase_d = '0;
          step_d  = '0;
          state_d = ST_SCAN;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_SCAN: begin
        if (phase_q == PHASE_LAST) begin
          scan_sample = 1'b1;
          phase_d     = '0;
          if (step_q == STEP_LAST) state_d = ST_UPDATE;
          else                     step_d  = step_q + 3'd1;
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      ST_UPDATE: begin
        scan_update = 1'b1;
        step_d      = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Select follows the state being entered so it flips on a step's first cycle.
    sel_d = !(state_d == ST_SCAN && step_d[0]);
  end

  assign JOY_SELECT = sel_q;

  joy_mux_reader_if p1_if ();
  joy_mux_reader_if p2_if ();

  assign p1_if.pad    = j1_sync_q;
  assign p1_if.sample = scan_sample;
  assign p1_if.step   = step_q;
  assign p1_if.update = scan_update;
  assign p2_if.pad    = j2_sync_q;
  assign p2_if.sample = scan_sample;
  assign p2_if.step   = step_q;
  assign p2_if.update = scan_update;

  joy_port_decode u_port1 (.clk(clk), .reset(reset), .bus(p1_if));
  joy_port_decode u_port2 (.clk(clk), .reset(reset), .bus(p2_if));

  assign joy1      = p1_if.joy;
  assign joy1_ext  = p1_if.ext;
  assign joy1_6btn = p1_if.six;
  assign joy2      = p2_if.joy;
  assign joy2_ext  = p2_if.ext;
  assign joy2_6btn = p2_if.six;

endmodule

// File: doc/joy_mux_reader.md
JOY_MUX_READER -- requirements
Module: joy_mux_reader

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 500: clk cycles per select step (10 us at 50 MHz).
REQ-002 SHALL have parameter IDLE_CYCLES, default 100000: clk cycles of select-high gap between scans (2 ms; at least 1.6 ms for 6-button pad counter reset).
REQ-003 SHALL have port clk, input, 1: single system clock (CLOCK_50 domain).
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port JOYSTICK1, input, 6: raw DB9 port 1, active-low, [0]=up [1]=down [2]=left [3]=right [4]=B/fire1 [5]=C/fire2.
REQ-006 SHALL have port JOYSTICK2, input, 6: raw DB9 port 2, same mapping.
REQ-007 SHALL have port JOY_SELECT, output, 1: select line driven to both ports.
REQ-008 SHALL have ports joy1 and joy2, output, 8 each: active-low {start, A, fire2, fire1, up, down, left, right}, bit7..bit0, consumed directly by the controller joy inputs.
REQ-009 SHALL have ports joy1_ext and joy2_ext, output, 4 each: active-low {mode, X, Y, Z}, bit3..bit0.
REQ-010 SHALL have ports joy1_6btn and joy2_6btn, output, 1 each: high when a 6-button pad was detected in the last completed scan.

Function
REQ-011 SHALL pass each JOYSTICKn bit through a 2-flop synchroniser; all samples use synchronised values.
REQ-012 SHALL run states IDLE -> SCAN(step 0..7) -> UPDATE -> IDLE, forever.
REQ-013 IDLE: JOY_SELECT=1 for IDLE_CYCLES cycles, then enter SCAN step 0.
REQ-014 SCAN step k SHALL last PHASE_CYCLES cycles with JOY_SELECT=1 for even k and 0 for odd k; the select value changes on the first cycle of the step.
REQ-015 Each port SHALL be sampled on the last cycle of every step into per-port shadow registers; outputs are not touched during SCAN.
REQ-016 Step 0 sample SHALL provide up/down/left/right/fire1/fire2.
REQ-017 Step 1 sample: left and right both low SHALL mark a Sega pad present; if present, bit4 gives A and bit5 gives start.
REQ-018 Step 5 sample: pad present and up/down/left/right all low SHALL mark a 6-button pad.
REQ-019 Step 6 sample, 6-button pad only: bits [0],[1],[2],[3] SHALL give Z, Y, X, mode.
REQ-020 UPDATE (one cycle) SHALL load joyN, joyN_ext and joyN_6btn from the shadows in the same cycle, so every output changes atomically.
REQ-021 No Sega pad: joyN[7:6]=2'b11, joyN[5:0] from step 0, joyN_ext=4'hF, joyN_6btn=0.
REQ-022 3-button pad: joyN_ext=4'hF and joyN_6btn=0.
REQ-023 The two ports SHALL be decoded independently; pad type on one port never affects the other.
REQ-024 Phase and idle counters SHALL be wide enough for their parameters and SHALL wrap only through state transitions, never by overflow.
REQ-025 A full scan period SHALL be exactly IDLE_CYCLES + 8*PHASE_CYCLES + 1 cycles.

Reset
REQ-026 While reset is high at a clk edge: state=IDLE, counters=0, JOY_SELECT=1, joy1=joy2=8'hFF, joy1_ext=joy2_ext=4'hF, joyN_6btn=0, shadows=all-ones, synchronisers=all-ones.
REQ-027 Reset asserted mid-SCAN SHALL abort the scan; no partial result reaches the outputs, and the first update after release follows a full IDLE gap.

Structure
REQ-028 Shared package joy_pkg SHALL hold the step count (8), sample step indices (0, 1, 5, 6), output bit-index constants and the state enum.
REQ-029 Per-port sampling and decoding SHALL be a sub-module joy_port_decode, instantiated twice; the top holds the synchronisers, the sequencer and the select driver.

Verification
REQ-030 Atari stick, up and fire1 held low (JOYSTICK1=6'b101110), PHASE_CYCLES=4, IDLE_CYCLES=16 -> after first UPDATE joy1=8'hE7, joy1_ext=4'hF, joy1_6btn=0.
REQ-031 3-button pad model, A and start pressed -> joy1=8'h3F, joy1_6btn=0, joy1_ext=4'hF.
REQ-032 6-button pad model on port 2, X and mode pressed, no other button -> joy2=8'hFF, joy2_ext=4'h3, joy2_6btn=1; port 1 unaffected (8'hFF).
REQ-033 Monitor JOY_SELECT over one period -> low exactly in steps 1, 3, 5, 7; period equals REQ-025 value (49 cycles for 4/16).
REQ-034 Reset pulsed during step 3 with a button pressed -> outputs stay at reset values until the next full scan completes.
REQ-035 Input changes during SCAN -> outputs change only on UPDATE cycles, all output bits in the same cycle.
